// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory bus bundle for the load/store unit
interface load_store_unit_if #(parameter int ADDR_W = 14);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic [31:0]       read_data;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, address, write_data
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, address, write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store initiator for a word-addressed synchronous data memory
// Sub-word stores use read-modify-write since the memory has no byte enables.
module load_store_unit #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] CAP  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  logic [2:0]        state;
  logic              store_q;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wbuf_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic        f3_ok;
  logic        align_ok;
  logic        range_ok;
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic [31:0] merged;

  always_comb begin
    f3_ok = 1'b0;
    if (bus.req_store)
      f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
    else
      f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    align_ok = 1'b1;
    case (bus.req_funct3[1:0])
      2'b01:   align_ok = ~bus.req_addr[0];
      2'b10:   align_ok = (bus.req_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase

    range_ok = (bus.req_addr[31:ADDR_W+2] == '0);
  end

  // Lane extraction: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted  = bus.read_data >> {addr_q[1:0], 3'b000};
    load_ext = shifted;
    case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase

    merged = bus.read_data;
    if (f3_q[1:0] == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = wbuf_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wbuf_q[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      store_q <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wbuf_q  <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            store_q <= bus.req_store;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr[ADDR_W+1:0];
            wbuf_q  <= bus.req_wdata;
            if (!(f3_ok && align_ok && range_ok)) begin
              rdata_q <= 32'd0;
              err_q   <= 1'b1;
              state   <= RESP;
            end else if (bus.req_store && bus.req_funct3 == 3'b010) begin
              state   <= WR;
            end else begin
              state   <= RD;
            end
          end
        end
        RD: state <= CAP;
        CAP: begin
          if (store_q) begin
            wbuf_q <= merged;
            state  <= WR;
          end else begin
            rdata_q <= load_ext;
            err_q   <= 1'b0;
            state   <= RESP;
          end
        end
        WR: begin
          rdata_q <= 32'd0;
          err_q   <= 1'b0;
          state   <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_read   = (state == RD);
  assign bus.mem_write  = (state == WR);
  assign bus.address    = addr_q[ADDR_W+1:2];
  assign bus.write_data = wbuf_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit with a synchronous memory model
module tb_load_store_unit;
  localparam int ADDR_W = 14;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus();

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.address] <= bus.write_data;
    if (bus.mem_read)  bus.read_data <= mem[bus.address];
  end

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er, output logic saw_rd, output logic saw_wr,
                        output logic [ADDR_W-1:0] wa, output logic [31:0] wdat);
    lat = 0; rd = 32'hx; er = 1'bx; saw_rd = 1'b0; saw_wr = 1'b0; wa = '0; wdat = 32'd0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (bus.mem_read) saw_rd = 1'b1;
      if (bus.mem_write) begin
        saw_wr = 1'b1; wa = bus.address; wdat = bus.write_data;
      end
      if (bus.resp_valid) begin
        lat = k; rd = bus.resp_rdata; er = bus.resp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    checks++; if (bus.mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read got=%b exp=0", bus.mem_read); end
    checks++; if (bus.mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%b exp=0", bus.mem_write); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    checks++; if (bus.resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err got=%b exp=0", bus.resp_err); end
    checks++; if (bus.resp_rdata !== 32'd0) begin failures++; $display("FAIL reset_resp_rdata got=%h exp=0", bus.resp_rdata); end
    checks++; if (bus.address !== '0) begin failures++; $display("FAIL reset_address got=%h exp=0", bus.address); end
    checks++; if (bus.write_data !== 32'd0) begin failures++; $display("FAIL reset_write_data got=%h exp=0", bus.write_data); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_req_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_sw;
    int lat; logic [31:0] rd, wdat; logic er, srd, swr; logic [ADDR_W-1:0] wa;
    do_req(1'b1, 3'b010, 32'h0000_0010, 32'hDEADBEEF, lat, rd, er, srd, swr, wa, wdat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", lat); end
    checks++; if (swr !== 1'b1) begin failures++; $display("FAIL sw_mem_write got=%b exp=1", swr); end
    checks++; if (srd !== 1'b0) begin failures++; $display("FAIL sw_no_read got=%b exp=0", srd); end
    checks++; if (wa !== 14'd4) begin failures++; $display("FAIL sw_address got=%0d exp=4", wa); end
    checks++; if (wdat !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_write_data got=%h exp=deadbeef", wdat); end
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin failures++; $display("FAIL sw_resp got_err=%b got_rdata=%h exp_err=0 exp_rdata=0", er, rd); end
  endtask

  task automatic test_loads;
    logic [2:0]  f3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ad [5] = '{32'h11, 32'h13, 32'h12, 32'h10, 32'h10};
    logic [31:0] ex [5] = '{32'hFFFFFFBE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF, 32'hDEADBEEF};
    int lat; logic [31:0] rd, wdat; logic er, srd, swr; logic [ADDR_W-1:0] wa;
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, f3[i], ad[i], 32'd0, lat, rd, er, srd, swr, wa, wdat);
      checks++; if (rd !== ex[i]) begin failures++; $display("FAIL load%0d_rdata got=%h exp=%h", i, rd, ex[i]); end
      checks++; if (lat !== 3 || er !== 1'b0 || swr !== 1'b0) begin failures++; $display("FAIL load%0d_timing got_lat=%0d got_err=%b got_wr=%b exp=3/0/0", i, lat, er, swr); end
    end
  endtask

  task automatic test_sub_stores;
    int lat; logic [31:0] rd, wdat; logic er, srd, swr; logic [ADDR_W-1:0] wa;
    do_req(1'b1, 3'b000, 32'h11, 32'h000000AA, lat, rd, er, srd, swr, wa, wdat);
    checks++; if (wdat !== 32'hDEADAAEF) begin failures++; $display("FAIL sb_write_data got=%h exp=deadaaef", wdat); end
    checks++; if (lat !== 4 || wa !== 14'd4 || srd !== 1'b1 || er !== 1'b0) begin failures++; $display("FAIL sb_access got_lat=%0d got_addr=%0d got_rd=%b got_err=%b exp=4/4/1/0", lat, wa, srd, er); end
    do_req(1'b1, 3'b001, 32'h12, 32'h00001234, lat, rd, er, srd, swr, wa, wdat);
    checks++; if (wdat !== 32'h1234AAEF) begin failures++; $display("FAIL sh_write_data got=%h exp=1234aaef", wdat); end
    checks++; if (lat !== 4 || wa !== 14'd4 || rd !== 32'd0) begin failures++; $display("FAIL sh_access got_lat=%0d got_addr=%0d got_rdata=%h exp=4/4/0", lat, wa, rd); end
    do_req(1'b0, 3'b010, 32'h10, 32'd0, lat, rd, er, srd, swr, wa, wdat);
    checks++; if (rd !== 32'h1234AAEF) begin failures++; $display("FAIL rmw_readback got=%h exp=1234aaef", rd); end
  endtask

  task automatic test_errors;
    logic        st [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3 [5] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b100};
    logic [31:0] ad [5] = '{32'h12, 32'h13, 32'h10, 32'h0001_0000, 32'h10};
    int lat; logic [31:0] rd, wdat; logic er, srd, swr; logic [ADDR_W-1:0] wa;
    for (int i = 0; i < 5; i++) begin
      do_req(st[i], f3[i], ad[i], 32'hFFFF_FFFF, lat, rd, er, srd, swr, wa, wdat);
      checks++; if (er !== 1'b1 || lat !== 1) begin failures++; $display("FAIL err%0d_flag got_err=%b got_lat=%0d exp=1/1", i, er, lat); end
      checks++; if (rd !== 32'd0 || srd !== 1'b0 || swr !== 1'b0) begin failures++; $display("FAIL err%0d_side got_rdata=%h got_rd=%b got_wr=%b exp=0/0/0", i, rd, srd, swr); end
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] rd, wdat; logic er, srd, swr, saw; logic [ADDR_W-1:0] wa;
    do_req(1'b1, 3'b010, 32'h14, 32'h11111111, lat, rd, er, srd, swr, wa, wdat);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h14; bus.req_wdata = 32'h55;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++; if (bus.mem_read !== 1'b1) begin failures++; $display("FAIL mid_in_rd got=%b exp=1", bus.mem_read); end
    reset = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1 || bus.mem_read !== 1'b0) begin failures++; $display("FAIL mid_abort got_ready=%b got_read=%b exp=1/0", bus.req_ready, bus.mem_read); end
    saw = 1'b0;
    repeat (3) begin @(negedge clk); if (bus.mem_write) saw = 1'b1; end
    reset = 1'b1;
    repeat (3) begin @(negedge clk); if (bus.mem_write) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL mid_no_write got=%b exp=0", saw); end
    do_req(1'b0, 3'b010, 32'h14, 32'd0, lat, rd, er, srd, swr, wa, wdat);
    checks++; if (rd !== 32'h11111111) begin failures++; $display("FAIL mid_mem_intact got=%h exp=11111111", rd); end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  f3 [3] = '{3'b010, 3'b000, 3'b101};
    logic [31:0] ad [3] = '{32'h10, 32'h11, 32'h12};
    logic [31:0] ex [3] = '{32'h1234AAEF, 32'hFFFFFFAA, 32'h00001234};
    int acc [3];
    logic [31:0] got [3];
    int idx, nresp, cyc;
    idx = 0; nresp = 0; cyc = 0;
    for (int i = 0; i < 3; i++) begin acc[i] = 0; got[i] = 32'd0; end
    repeat (30) begin
      @(negedge clk);
      cyc++;
      if (bus.resp_valid && nresp < 3) begin got[nresp] = bus.resp_rdata; nresp++; end
      if (idx < 3) begin
        bus.req_valid = 1'b1; bus.req_store = 1'b0;
        bus.req_funct3 = f3[idx]; bus.req_addr = ad[idx]; bus.req_wdata = 32'd0;
        if (bus.req_ready) begin acc[idx] = cyc; idx++; end
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    checks++; if (nresp !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", nresp); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got[i] !== ex[i]) begin failures++; $display("FAIL b2b_resp%0d got=%h exp=%h", i, got[i], ex[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      checks++; if (acc[i] - acc[i-1] !== 4) begin failures++; $display("FAIL b2b_gap%0d got=%0d exp=4", i, acc[i] - acc[i-1]); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0;
    test_reset();
    test_sw();
    test_loads();
    test_sub_stores();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
